// File: rtl/axi_burst_master.sv
// axi_burst_master
// Command-driven AXI4 master. Each accepted command issues exactly one INCR
// burst: a write burst whose beats come from the local wr_* stream, or a
// read burst whose beats are handed to the local rd_* stream. Completion is
// reported with a one-cycle done_valid pulse carrying the final response
// and a beat-count/last mismatch flag.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   cmd_valid/ready            command handshake
//   cmd_write/addr/len         direction, byte start address, beats-1
//   wr_data/valid/ready        local write-data stream (pass-through to W)
//   rd_data/last/valid/ready   local read-data stream (pass-through from R)
//   done_valid/resp/err        completion pulse, response, mismatch flag
//   busy                       high while a command is in progress
//   m_axi_aw*/w*/b*/ar*/r*     AXI4 master channels
module axi_burst_master #(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ADDR_WIDTH = 16,
    parameter int                  STRB_WIDTH = DATA_WIDTH / 8,
    parameter int                  ID_WIDTH   = 1,
    parameter logic [ID_WIDTH-1:0] AXI_ID     = '0
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,

    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,

    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  rd_valid,
    input  logic                  rd_ready,

    output logic                  done_valid,
    output logic [1:0]            done_resp,
    output logic                  done_err,
    output logic                  busy,

    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,

    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,

    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,

    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam logic [2:0]            AXSIZE     = 3'($clog2(STRB_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, AW, W, B, AR, R} state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [7:0]              len;
    logic [7:0]              cnt;     // beats remaining minus 1
    logic [1:0]              sticky;  // first non-OKAY rresp of this burst
    logic                    done_next, err_next;
    logic [1:0]              resp_next;
    logic                    cmd_fire, w_fire, r_fire;

    // IDs are constant and there is one burst in flight, so returned IDs carry no information.
    logic unused_ids;
    assign unused_ids = ^{m_axi_bid, m_axi_rid};

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign cmd_fire  = cmd_valid && (state == IDLE);
    assign w_fire    = (state == W) && wr_valid && m_axi_wready;
    assign r_fire    = (state == R) && m_axi_rvalid && rd_ready;

    // Address channels: valid is a pure state decode, so it rises one cycle
    // after the command handshake and drops the cycle after its own handshake.
    assign m_axi_awid    = AXI_ID;
    assign m_axi_awaddr  = addr;
    assign m_axi_awlen   = len;
    assign m_axi_awsize  = AXSIZE;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = (state == AW);

    assign m_axi_arid    = AXI_ID;
    assign m_axi_araddr  = addr;
    assign m_axi_arlen   = len;
    assign m_axi_arsize  = AXSIZE;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = (state == AR);

    // Data channels are combinational pass-throughs, gated by state.
    assign m_axi_wdata  = wr_data;
    assign m_axi_wstrb  = '1;
    assign m_axi_wlast  = (state == W) && (cnt == 8'd0);
    assign m_axi_wvalid = (state == W) && wr_valid;
    assign wr_ready     = (state == W) && m_axi_wready;

    assign m_axi_bready = (state == B);

    assign rd_data      = m_axi_rdata;
    assign rd_last      = m_axi_rlast;
    assign rd_valid     = (state == R) && m_axi_rvalid;
    assign m_axi_rready = (state == R) && rd_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        resp_next  = done_resp;
        err_next   = done_err;
        case (state)
            IDLE: if (cmd_valid) state_next = cmd_write ? AW : AR;
            AW:   if (m_axi_awready) state_next = W;
            AR:   if (m_axi_arready) state_next = R;
            W:    if (w_fire && cnt == 8'd0) state_next = B;
            B: begin
                if (m_axi_bvalid) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    resp_next  = m_axi_bresp;
                    err_next   = 1'b0;
                end
            end
            R: begin
                // rlast ends the burst wherever it lands; running out of
                // beats without rlast also ends it. Either mismatch is flagged.
                if (r_fire && (m_axi_rlast || cnt == 8'd0)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    resp_next  = (sticky != 2'b00) ? sticky : m_axi_rresp;
                    err_next   = m_axi_rlast ? (cnt != 8'd0) : 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr       <= '0;
            len        <= '0;
            cnt        <= '0;
            sticky     <= 2'b00;
            done_valid <= 1'b0;
            done_resp  <= 2'b00;
            done_err   <= 1'b0;
        end else begin
            done_valid <= done_next;
            done_resp  <= resp_next;
            done_err   <= err_next;
            if (cmd_fire) begin
                addr   <= cmd_addr & ALIGN_MASK;
                len    <= cmd_len;
                cnt    <= cmd_len;
                sticky <= 2'b00;
            end
            if (w_fire || r_fire) cnt <= cnt - 8'd1;
            if (r_fire && sticky == 2'b00) sticky <= m_axi_rresp;
        end
    end

endmodule
